gate_vector_checker: RTL and testbench
======================================

# gate_vector_checker

Self-checking stimulus and response stage for 2-input logic-gate DUTs such as `nand_gate`. It drives all four `{a,b}` input vectors to the gate, holds each vector for a programmable number of cycles, and samples the gate output on the last hold cycle. Each sample is compared against a 4-bit truth table, and the block reports a pass/fail verdict, an error count and the first failing vector. It replaces the free-running toggle stimulus in gate benches and can also be instantiated on-chip as a built-in gate self-test.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: cycles each vector is held; legal range ≥1.
- `ERR_W`, default 3: width of the error counter.

Ports:
- `clk` — input, 1 — single clock; all logic on the rising edge.
- `rst` — input, 1 — synchronous, active-high reset.
- `start` — input, 1 — begin a check run; honoured only in IDLE.
- `truth_table` — input, 4 — expected output per vector; bit index = `{a,b}`.
- `gate_out` — input, 1 — DUT output; combinational function of `a`/`b`.
- `a` — output, 1 — DUT input A, registered.
- `b` — output, 1 — DUT input B, registered.
- `busy` — output, 1 — high while in DRIVE.
- `done` — output, 1 — one-cycle pulse when a run completes.
- `pass` — output, 1 — high when the last run had zero mismatches.
- `err_count` — output, ERR_W — mismatches in the last/current run; saturates at max.
- `fail_valid` — output, 1 — high when at least one mismatch has been seen this run.
- `first_fail_vec` — output, 2 — `{a,b}` of the first mismatch; valid when `fail_valid` is high.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - `a`/`b` are held at 0.
  - On `start`, go to DRIVE with `vec`=0 and `hold_cnt`=0. `truth_table` is captured into an internal register at this point.
  - `err_count`, `fail_valid` and `first_fail_vec` are cleared at the same time.
- DRIVE:
  - `{a,b}` = `vec`.
  - `hold_cnt` increments every cycle.
  - When `hold_cnt` == HOLD_CYCLES-1, compare `gate_out` to `tt_q[vec]`:
    - On mismatch, `err_count`++ (saturating).
    - On the first mismatch, set `fail_valid` and latch `first_fail_vec`=`vec`.
  - On that same cycle, `hold_cnt` returns to 0 and `vec` advances.
  - After vector 3 is sampled, go to DONE.
- Vector order is fixed: 00, 01, 10, 11.
- DONE:
  - Lasts one cycle. `done`=1 and `pass` = (`err_count`==0 including the final sample); then go to IDLE.
- `pass`, `err_count`, `fail_valid` and `first_fail_vec` hold their values until the next accepted `start`.
- `start` is ignored in DRIVE and DONE; there is no queuing.
- Changing `truth_table` mid-run has no effect, because the captured copy is used.

## Timing
- Reset values:
  - state=IDLE, `a`=`b`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_valid`=0, `first_fail_vec`=0.
- Reset asserted mid-run aborts the run on the next edge: outputs return to their reset values and no `done` is produced.
- Cycle numbering: cycle 0 = the first cycle after the edge that samples `start`.
  - `busy`=1 and `{a,b}`=00 in cycle 0.
  - Vector k is driven in cycles k·H … k·H+H-1, where H = HOLD_CYCLES.
  - `gate_out` for vector k is sampled at the edge ending cycle k·H+H-1.
- `done` and the final `pass` appear in cycle 4·H; `busy`=0 in that cycle.
- `start` in cycle 4·H+1 (back in IDLE) is accepted, so back-to-back runs have a one-cycle gap.
- H=1: each vector is driven for exactly one cycle.
- The bench must use zero-delay gate models. Combinational `gate_out` must settle within the same cycle.

## Structure
- Package `gate_check_pkg` holds:
  - the state enum (IDLE/DRIVE/DONE);
  - truth-table constants, index `{a,b}`: TT_AND=4'b1000, TT_NAND=4'b0111, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One sub-module is natural: `gate_vec_seq`, containing the hold counter and the 2-bit vector counter.
  - Outputs: `vec` and `sample_en` (the last hold cycle), plus a `last` flag (vec==3 && sample_en).
- The top level contains the FSM, the comparator and the result registers.

## Test plan
- Correct NAND DUT, `truth_table`=TT_NAND, H=2, pulse `start`:
  - `a`/`b` step 00,01,10,11 every 2 cycles.
  - `done` in cycle 8; `pass`=1, `err_count`=0, `fail_valid`=0.
- Same run with the DUT replaced by an AND gate, `truth_table`=TT_NAND:
  - Every vector mismatches, so `err_count`=4 and `pass`=0.
  - `fail_valid`=1, `first_fail_vec`=00.
- NAND DUT, `truth_table`=4'b1111 (wrong at vector 11 only):
  - `err_count`=1, `first_fail_vec`=11, `pass`=0.
- H=1 with an XOR DUT and TT_XOR:
  - `done` in cycle 4, `pass`=1.
  - Re-pulse `start` the cycle after `done`: the second run starts immediately and also passes.
- Re-assert `start` in cycle 3 of a run: it is ignored and there is a single `done`.
  - Assert `rst` in cycle 5 of a later run: next cycle `a`=`b`=0, `busy`=0, `err_count`=0, and no `done` ever fires.
- ERR_W=1 with all vectors mismatching: `err_count` saturates at 1, and `pass`=0.

Source files
------------

// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types and truth-table constants for the gate vector checker
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Truth tables are indexed by {a,b}: bit 0 is vector 00, bit 3 is vector 11.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam logic [1:0] VEC_LAST = 2'b11;

endpackage

// File: rtl/gate_vec_seq.sv
// rtl/gate_vec_seq.sv - hold counter and 2-bit vector counter for the gate vector checker
module gate_vec_seq
    import gate_check_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] vec,
    output logic       sample_en,
    output logic       last
);

    // A one-cycle hold still needs a one-bit counter so the compare stays legal.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_hold_cnt;
    logic [1:0]    r_vec;

    // Counters sit at zero whenever not enabled, so a new run always begins at vector 00.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_hold_cnt <= '0;
            r_vec      <= '0;
        end else if (sample_en) begin
            r_hold_cnt <= '0;
            r_vec      <= r_vec + 2'd1;
        end else begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
        end
    end

    assign vec       = r_vec;
    assign sample_en = en && (r_hold_cnt == HOLD_MAX);
    assign last      = sample_en && (r_vec == VEC_LAST);

endmodule

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - drives all four {a,b} vectors to a 2-input gate and checks its output
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       truth_table,
    input  logic             gate_out,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       first_fail_vec
);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_tt;
    logic [ERR_W-1:0] r_err_count;
    logic             r_fail_valid;
    logic [1:0]       r_first_fail_vec;
    logic             r_pass;

    logic             w_start_acc;
    logic             w_drive;
    logic [1:0]       w_vec;
    logic             w_sample_en;
    logic             w_last;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_drive     = (r_state == ST_DRIVE);

    gate_vec_seq #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .en       (w_drive),
        .vec      (w_vec),
        .sample_en(w_sample_en),
        .last     (w_last)
    );

    // Compare against the copy captured at start, so mid-run truth_table changes are ignored.
    assign w_mismatch = w_sample_en && (gate_out != r_tt[w_vec]);
    assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only counts in IDLE, DONE lasts a single cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_DRIVE;
            ST_DRIVE: if (w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Result registers: cleared on an accepted start, updated on each sample, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tt             <= '0;
            r_err_count      <= '0;
            r_fail_valid     <= 1'b0;
            r_first_fail_vec <= '0;
            r_pass           <= 1'b0;
        end else if (w_start_acc) begin
            r_tt             <= truth_table;
            r_err_count      <= '0;
            r_fail_valid     <= 1'b0;
            r_first_fail_vec <= '0;
            r_pass           <= 1'b0;
        end else begin
            r_err_count <= w_err_next;
            if (w_mismatch && !r_fail_valid) begin
                r_fail_valid     <= 1'b1;
                r_first_fail_vec <= w_vec;
            end
            // The verdict must include the final sample, hence the next-value count.
            if (w_last) begin
                r_pass <= (w_err_next == '0);
            end
        end
    end

    assign a              = w_drive & w_vec[1];
    assign b              = w_drive & w_vec[0];
    assign busy           = w_drive;
    assign done           = (r_state == ST_DONE);
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign fail_valid     = r_fail_valid;
    assign first_fail_vec = r_first_fail_vec;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb/tb_gate_vector_checker.sv - self-checking bench for gate_vector_checker
module tb_gate_vector_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st[3];
    logic [3:0] tt_in[3];
    logic [3:0] gtab[3];

    logic       g0, g1, g2;
    logic       a0, a1, a2, b0, b1, b2;
    logic       busy0, busy1, busy2, done0, done1, done2;
    logic       pass0, pass1, pass2, fv0, fv1, fv2;
    logic [1:0] ff0, ff1, ff2;
    logic [2:0] ec0, ec1;
    logic [0:0] ec2;

    // Zero-delay gate models: each DUT gate is a lookup of its own actual truth table.
    assign g0 = gtab[0][{a0, b0}];
    assign g1 = gtab[1][{a1, b1}];
    assign g2 = gtab[2][{a2, b2}];

    gate_vector_checker #(.HOLD_CYCLES(2), .ERR_W(3)) u_h2 (
        .clk(clk), .rst(rst), .start(st[0]), .truth_table(tt_in[0]), .gate_out(g0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(ec0), .fail_valid(fv0), .first_fail_vec(ff0));

    gate_vector_checker #(.HOLD_CYCLES(1), .ERR_W(3)) u_h1 (
        .clk(clk), .rst(rst), .start(st[1]), .truth_table(tt_in[1]), .gate_out(g1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .fail_valid(fv1), .first_fail_vec(ff1));

    gate_vector_checker #(.HOLD_CYCLES(3), .ERR_W(1)) u_e1 (
        .clk(clk), .rst(rst), .start(st[2]), .truth_table(tt_in[2]), .gate_out(g2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(ec2), .fail_valid(fv2), .first_fail_vec(ff2));

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic       fv;
        logic [1:0] ff;
        logic [2:0] ec;
    } obs_t;

    typedef struct {
        int         inst;
        logic [3:0] g;
        logic [3:0] t;
        int         err;
        int         ff;
        int         fv;
        int         ps;
        int         restart_at;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic obs_t get_obs(input int inst);
        obs_t o;
        case (inst)
            0:       o = '{a0, b0, busy0, done0, pass0, fv0, ff0, ec0};
            1:       o = '{a1, b1, busy1, done1, pass1, fv1, ff1, ec1};
            default: o = '{a2, b2, busy2, done2, pass2, fv2, ff2, {2'b00, ec2}};
        endcase
        return o;
    endfunction

    function automatic int hold_of(input int inst);
        return (inst == 0) ? 2 : (inst == 1) ? 1 : 3;
    endfunction

    function automatic int errmax_of(input int inst);
        return (inst == 2) ? 1 : 7;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: count differing truth-table bits, lowest differing index is the first failure.
    task automatic model(input int inst, input logic [3:0] g, input logic [3:0] t,
                         output int err, output int ff, output int fv, output int ps);
        int cnt = 0;
        ff = 0;
        fv = 0;
        for (int v = 0; v < 4; v++) begin
            if (g[v] != t[v]) begin
                if (fv == 0) ff = v;
                fv = 1;
                cnt++;
            end
        end
        err = (cnt > errmax_of(inst)) ? errmax_of(inst) : cnt;
        ps  = (cnt == 0) ? 1 : 0;
    endtask

    // Called just after a rising edge; returns just after the edge that ends cycle 4H.
    task automatic run_one(input vec_t v, input string tag);
        int   h = hold_of(v.inst);
        obs_t o;
        gtab[v.inst]  = v.g;
        tt_in[v.inst] = v.t;
        st[v.inst]    = 1'b1;
        @(posedge clk); #1;
        st[v.inst] = 1'b0;
        for (int c = 0; c <= 4 * h; c++) begin
            if (c == 2) tt_in[v.inst] = 4'($urandom);
            st[v.inst] = (c == v.restart_at);
            o = get_obs(v.inst);
            if (c < 4 * h) begin
                check({tag, " busy"}, o.busy, 1);
                check({tag, " ab"}, {o.a, o.b}, c / h);
                check({tag, " no_done"}, o.done, 0);
            end else begin
                check({tag, " done"}, o.done, 1);
                check({tag, " busy_end"}, o.busy, 0);
                check({tag, " pass"}, o.pass, v.ps);
                check({tag, " err"}, o.ec, v.err);
                check({tag, " fail_valid"}, o.fv, v.fv);
                check({tag, " first_fail"}, o.ff, v.ff);
            end
            @(posedge clk); #1;
        end
        st[v.inst] = 1'b0;
        o = get_obs(v.inst);
        check({tag, " done_once"}, o.done, 0);
        check({tag, " pass_hold"}, o.pass, v.ps);
        check({tag, " err_hold"}, o.ec, v.err);
    endtask

    vec_t tbl[12];

    initial begin
        obs_t o;
        vec_t rv;

        tbl[0]  = '{0, TT_NAND, TT_NAND, 0, 0, 0, 1, -1};
        tbl[1]  = '{0, TT_AND,  TT_NAND, 4, 0, 1, 0, -1};
        tbl[2]  = '{0, TT_NAND, 4'b1111, 1, 3, 1, 0, -1};
        tbl[3]  = '{1, TT_XOR,  TT_XOR,  0, 0, 0, 1, -1};
        tbl[4]  = '{1, TT_XOR,  TT_XOR,  0, 0, 0, 1, -1};
        tbl[5]  = '{0, TT_NAND, TT_NAND, 0, 0, 0, 1, 3};
        tbl[6]  = '{2, TT_AND,  TT_NAND, 1, 0, 1, 0, -1};
        tbl[7]  = '{0, TT_OR,   TT_NOR,  4, 0, 1, 0, -1};
        tbl[8]  = '{1, TT_XNOR, TT_XOR,  4, 0, 1, 0, -1};
        tbl[9]  = '{0, TT_OR,   TT_AND,  2, 1, 1, 0, -1};
        tbl[10] = '{2, TT_NAND, TT_NAND, 0, 0, 0, 1, -1};
        tbl[11] = '{1, TT_AND,  4'b1010, 1, 1, 1, 0, -1};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i]    = 1'b0;
            tt_in[i] = 4'h0;
            gtab[i]  = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            o = get_obs(i);
            check($sformatf("reset_state inst%0d", i), o, '0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Entries 3 and 4 run back to back: the second start lands in cycle 4H+1.
        for (int i = 0; i < 12; i++) begin
            run_one(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            rv.inst       = $urandom_range(0, 2);
            rv.g          = 4'($urandom);
            rv.t          = 4'($urandom);
            rv.restart_at = (i % 3 == 0) ? 1 : -1;
            model(rv.inst, rv.g, rv.t, rv.err, rv.ff, rv.fv, rv.ps);
            run_one(rv, $sformatf("rand%0d", i));
            @(posedge clk); #1;
        end

        // Reset in cycle 5 of a failing H=2 run aborts it with no done.
        gtab[0]  = TT_AND;
        tt_in[0] = TT_NAND;
        st[0]    = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        o = get_obs(0);
        check("rst_pre err", o.ec, 2);
        check("rst_pre ab", {o.a, o.b}, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        o = get_obs(0);
        check("rst_abort ab", {o.a, o.b}, 0);
        check("rst_abort busy", o.busy, 0);
        check("rst_abort err", o.ec, 0);
        check("rst_abort done", o.done, 0);
        check("rst_abort fv", o.fv, 0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            o = get_obs(0);
            check("rst_abort no_done", o.done, 0);
            check("rst_abort idle", o.busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
